// File: rtl/uart_rx_cfg_ctrl.sv
// Configuration controller for the UART receive path: owns the live prescale/parity
// settings and swaps them only after draining in-flight frames and waiting for line idle.
module uart_rx_cfg_ctrl #(
    parameter int unsigned IDLE_BITS = 2
) (
    input  logic       clk,
    input  logic       asy_reset,
    input  logic       RX_IN,
    input  logic       rx_busy,
    input  logic       cfg_req,
    input  logic [5:0] cfg_prescale,
    input  logic       cfg_parity_enable,
    input  logic       cfg_parity_type,
    output logic       cfg_ack,
    output logic       cfg_nack,
    output logic       rx_enable,
    output logic [5:0] prescale,
    output logic       parity_enable,
    output logic       parity_type
);

    localparam int unsigned PW = 6;
    localparam int unsigned CW = 8;
    localparam logic [PW-1:0] RESET_PRESCALE = PW'(8);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2,
        QUIET = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          drain_seen, drain_seen_nxt;
    logic [CW-1:0] quiet_cnt, quiet_cnt_nxt;
    logic [PW-1:0] sh_prescale, sh_prescale_nxt;
    logic          sh_parity_enable, sh_parity_enable_nxt;
    logic          sh_parity_type, sh_parity_type_nxt;
    logic [PW-1:0] prescale_nxt;
    logic          parity_enable_nxt, parity_type_nxt;
    logic          cfg_ack_nxt, cfg_nack_nxt, rx_enable_nxt;
    logic          prescale_legal_c;
    logic [CW-1:0] quiet_limit_c;

    assign prescale_legal_c = (cfg_prescale == PW'(8))  ||
                              (cfg_prescale == PW'(16)) ||
                              (cfg_prescale == PW'(32));

    // Idle requirement tracks the live prescale; worst case 7*32-1 still fits 8 bits.
    assign quiet_limit_c = CW'(IDLE_BITS * 32'(prescale) - 32'd1);

    always_ff @(posedge clk) begin
        if (asy_reset) begin
            state            <= QUIET;
            drain_seen       <= 1'b0;
            quiet_cnt        <= '0;
            sh_prescale      <= '0;
            sh_parity_enable <= 1'b0;
            sh_parity_type   <= 1'b0;
            prescale         <= RESET_PRESCALE;
            parity_enable    <= 1'b0;
            parity_type      <= 1'b0;
            cfg_ack          <= 1'b0;
            cfg_nack         <= 1'b0;
            rx_enable        <= 1'b0;
        end else begin
            state            <= state_nxt;
            drain_seen       <= drain_seen_nxt;
            quiet_cnt        <= quiet_cnt_nxt;
            sh_prescale      <= sh_prescale_nxt;
            sh_parity_enable <= sh_parity_enable_nxt;
            sh_parity_type   <= sh_parity_type_nxt;
            prescale         <= prescale_nxt;
            parity_enable    <= parity_enable_nxt;
            parity_type      <= parity_type_nxt;
            cfg_ack          <= cfg_ack_nxt;
            cfg_nack         <= cfg_nack_nxt;
            rx_enable        <= rx_enable_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        drain_seen_nxt       = drain_seen;
        quiet_cnt_nxt        = quiet_cnt;
        sh_prescale_nxt      = sh_prescale;
        sh_parity_enable_nxt = sh_parity_enable;
        sh_parity_type_nxt   = sh_parity_type;
        prescale_nxt         = prescale;
        parity_enable_nxt    = parity_enable;
        parity_type_nxt      = parity_type;
        cfg_nack_nxt         = 1'b0;

        case (state)
            RUN: begin
                if (cfg_req) begin
                    if (prescale_legal_c) begin
                        sh_prescale_nxt      = cfg_prescale;
                        sh_parity_enable_nxt = cfg_parity_enable;
                        sh_parity_type_nxt   = cfg_parity_type;
                        drain_seen_nxt       = 1'b0;
                        state_nxt            = DRAIN;
                    end else begin
                        cfg_nack_nxt = 1'b1;
                    end
                end
            end
            // Two consecutive idle samples cover the RX FSM's one-cycle start latency.
            DRAIN: begin
                if (rx_busy) begin
                    drain_seen_nxt = 1'b0;
                end else if (drain_seen) begin
                    prescale_nxt      = sh_prescale;
                    parity_enable_nxt = sh_parity_enable;
                    parity_type_nxt   = sh_parity_type;
                    state_nxt         = APPLY;
                end else begin
                    drain_seen_nxt = 1'b1;
                end
            end
            APPLY: begin
                quiet_cnt_nxt = '0;
                state_nxt     = QUIET;
            end
            QUIET: begin
                if (!RX_IN) begin
                    quiet_cnt_nxt = '0;
                end else if (quiet_cnt == quiet_limit_c) begin
                    quiet_cnt_nxt = '0;
                    state_nxt     = RUN;
                end else begin
                    quiet_cnt_nxt = quiet_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = QUIET;
            end
        endcase

        cfg_ack_nxt   = (state_nxt == APPLY);
        rx_enable_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Directed bench for uart_rx_cfg_ctrl: cycle-stepped vector table plus a hand-written
// drain-restart sequence and pulse counters for ack/nack.
module tb_uart_rx_cfg_ctrl;

    localparam int unsigned IDLE_BITS = 2;

    logic       clk = 1'b0;
    logic       asy_reset;
    logic       RX_IN;
    logic       rx_busy;
    logic       cfg_req;
    logic [5:0] cfg_prescale;
    logic       cfg_parity_enable;
    logic       cfg_parity_type;
    logic       cfg_ack;
    logic       cfg_nack;
    logic       rx_enable;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_seen  = 0;
    int nack_seen = 0;

    uart_rx_cfg_ctrl #(.IDLE_BITS(IDLE_BITS)) dut (
        .clk               (clk),
        .asy_reset         (asy_reset),
        .RX_IN             (RX_IN),
        .rx_busy           (rx_busy),
        .cfg_req           (cfg_req),
        .cfg_prescale      (cfg_prescale),
        .cfg_parity_enable (cfg_parity_enable),
        .cfg_parity_type   (cfg_parity_type),
        .cfg_ack           (cfg_ack),
        .cfg_nack          (cfg_nack),
        .rx_enable         (rx_enable),
        .prescale          (prescale),
        .parity_enable     (parity_enable),
        .parity_type       (parity_type)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_ack === 1'b1)  ack_seen++;
        if (cfg_nack === 1'b1) nack_seen++;
    end

    typedef struct {
        string      name;
        logic       rst;
        logic       rx;
        logic       busy;
        logic       req;
        logic [5:0] cps;
        logic       cpe;
        logic       cpt;
        int         cycles;
        logic       e_ack;
        logic       e_nack;
        logic       e_en;
        logic [5:0] e_ps;
        logic       e_pe;
        logic       e_pt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic rst, logic rx, logic busy, logic req,
                                logic [5:0] cps, logic cpe, logic cpt, int cyc,
                                logic ack, logic nack, logic en, logic [5:0] ps,
                                logic pe, logic pt);
        vec_t v;
        v.name = nm;   v.rst = rst;   v.rx = rx;     v.busy = busy;  v.req = req;
        v.cps = cps;   v.cpe = cpe;   v.cpt = cpt;   v.cycles = cyc;
        v.e_ack = ack; v.e_nack = nack; v.e_en = en; v.e_ps = ps;
        v.e_pe = pe;   v.e_pt = pt;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(string nm, logic ack, logic nack, logic en,
                               logic [5:0] ps, logic pe, logic pt);
        chk({nm, ".cfg_ack"},       8'(cfg_ack),       8'(ack));
        chk({nm, ".cfg_nack"},      8'(cfg_nack),      8'(nack));
        chk({nm, ".rx_enable"},     8'(rx_enable),     8'(en));
        chk({nm, ".prescale"},      8'(prescale),      8'(ps));
        chk({nm, ".parity_enable"}, 8'(parity_enable), 8'(pe));
        chk({nm, ".parity_type"},   8'(parity_type),   8'(pt));
    endtask

    initial begin
        int waited;

        asy_reset = 1'b1; RX_IN = 1'b1; rx_busy = 1'b0; cfg_req = 1'b0;
        cfg_prescale = 6'd0; cfg_parity_enable = 1'b0; cfg_parity_type = 1'b0;

        //                name               rst rx bsy req cps    pe pt cyc  ack nak en ps     pe pt
        vecs.push_back(mk("reset_hold",        1, 1, 0, 0, 6'd0,  0, 0,  2,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("reset_quiet",       0, 1, 0, 0, 6'd0,  0, 0, 15,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("reset_run",         0, 1, 0, 0, 6'd0,  0, 0,  1,  0, 0, 1, 6'd8,  0, 0));
        vecs.push_back(mk("legal_n1",          0, 1, 0, 1, 6'd16, 1, 1,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("legal_n2",          0, 1, 0, 1, 6'd16, 1, 1,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("legal_apply",       0, 1, 0, 1, 6'd16, 1, 1,  1,  1, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("legal_quiet",       0, 1, 0, 0, 6'd16, 1, 1,  1,  0, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("legal_quiet_end",   0, 1, 0, 0, 6'd16, 1, 1, 31,  0, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("legal_run",         0, 1, 0, 0, 6'd16, 1, 1,  1,  0, 0, 1, 6'd16, 1, 1));
        vecs.push_back(mk("illegal_nack",      0, 1, 0, 1, 6'd12, 0, 0,  1,  0, 1, 1, 6'd16, 1, 1));
        vecs.push_back(mk("illegal_after",     0, 1, 0, 0, 6'd12, 0, 0,  1,  0, 0, 1, 6'd16, 1, 1));
        vecs.push_back(mk("drain_n1",          0, 1, 1, 1, 6'd8,  0, 0,  1,  0, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("drain_busy",        0, 1, 1, 1, 6'd8,  0, 0, 39,  0, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("drain_low1",        0, 1, 0, 1, 6'd8,  0, 0,  1,  0, 0, 0, 6'd16, 1, 1));
        vecs.push_back(mk("drain_apply",       0, 1, 0, 1, 6'd8,  0, 0,  1,  1, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("drain_quiet",       0, 1, 0, 0, 6'd8,  0, 0,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("quiet_high10",      0, 1, 0, 0, 6'd8,  0, 0, 10,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("quiet_low",         0, 0, 0, 0, 6'd8,  0, 0,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("quiet_req_ignored", 0, 1, 0, 1, 6'd32, 1, 0, 15,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("quiet_run",         0, 1, 0, 1, 6'd32, 1, 0,  1,  0, 0, 1, 6'd8,  0, 0));
        vecs.push_back(mk("run_accept",        0, 1, 0, 1, 6'd32, 1, 0,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("reset_in_drain",    1, 1, 0, 1, 6'd32, 1, 0,  1,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("reset2_quiet",      0, 1, 0, 0, 6'd0,  0, 0, 15,  0, 0, 0, 6'd8,  0, 0));
        vecs.push_back(mk("reset2_run",        0, 1, 0, 0, 6'd0,  0, 0,  1,  0, 0, 1, 6'd8,  0, 0));

        foreach (vecs[i]) begin
            asy_reset         = vecs[i].rst;
            RX_IN             = vecs[i].rx;
            rx_busy           = vecs[i].busy;
            cfg_req           = vecs[i].req;
            cfg_prescale      = vecs[i].cps;
            cfg_parity_enable = vecs[i].cpe;
            cfg_parity_type   = vecs[i].cpt;
            step(vecs[i].cycles);
            chk_outputs(vecs[i].name, vecs[i].e_ack, vecs[i].e_nack, vecs[i].e_en,
                        vecs[i].e_ps, vecs[i].e_pe, vecs[i].e_pt);
        end

        // A busy blip inside DRAIN must restart the two-idle-sample requirement.
        cfg_req = 1'b1; cfg_prescale = 6'd16; cfg_parity_enable = 1'b0; cfg_parity_type = 1'b1;
        rx_busy = 1'b0;
        step(1); chk_outputs("blip_n1", 0, 0, 0, 6'd8, 0, 0);
        step(1); chk_outputs("blip_n2", 0, 0, 0, 6'd8, 0, 0);
        rx_busy = 1'b1;
        step(1); chk_outputs("blip_busy", 0, 0, 0, 6'd8, 0, 0);
        rx_busy = 1'b0;
        step(1); chk_outputs("blip_idle1", 0, 0, 0, 6'd8, 0, 0);
        step(1); chk_outputs("blip_apply", 1, 0, 0, 6'd16, 0, 1);
        cfg_req = 1'b0;
        step(1); chk_outputs("blip_quiet", 0, 0, 0, 6'd16, 0, 1);

        waited = 0;
        while (rx_enable !== 1'b1 && waited < 100) begin
            step(1);
            waited++;
        end
        chk("blip_quiet_cycles", 8'(waited), 8'(IDLE_BITS * 16));

        chk("ack_pulse_total",  8'(ack_seen),  8'd3);
        chk("nack_pulse_total", 8'(nack_seen), 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
